// File: rtl/stream_arb_2x1.sv
// Two-input round-robin valid/ready arbiter with packet locking and a registered output stage.
// sel is the combinational grant that steers the 2x1 payload mux and the per-source readys.
module stream_arb_2x1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    output logic             sel
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOCK_A = 2'd1;
    localparam logic [1:0] S_LOCK_B = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_prio;
    logic             w_prio_nxt;
    logic             r_sel;
    logic             w_sel;
    logic             w_load_en;
    logic             w_xfer;
    logic             w_last;
    logic [WIDTH-1:0] w_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_src;

    // Grant: locked source wins; in IDLE a lone requester wins, a tie goes to prio,
    // and with no requester the previous select is held.
    always_comb begin
        w_sel = r_sel;
        case (r_state)
            S_IDLE: begin
                if (a_valid && b_valid) begin
                    w_sel = r_prio;
                end else if (a_valid) begin
                    w_sel = 1'b0;
                end else if (b_valid) begin
                    w_sel = 1'b1;
                end
            end
            S_LOCK_A: w_sel = 1'b0;
            S_LOCK_B: w_sel = 1'b1;
            default:  w_sel = 1'b0;
        endcase
        if (rst) begin
            w_sel = 1'b0;
        end
    end

    assign w_load_en = (~r_out_valid | out_ready) & ~rst;
    assign a_ready   = w_load_en & ~w_sel;
    assign b_ready   = w_load_en & w_sel;
    assign w_xfer    = w_sel ? (b_valid & b_ready) : (a_valid & a_ready);
    assign w_last    = w_sel ? b_last : a_last;
    assign w_data    = w_sel ? b_data : a_data;
    assign sel       = w_sel;

    // Next-state: a last beat releases to IDLE and hands priority to the other source.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        if (w_xfer) begin
            if (w_last) begin
                w_state_nxt = S_IDLE;
                w_prio_nxt  = ~w_sel;
            end else begin
                w_state_nxt = w_sel ? S_LOCK_B : S_LOCK_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_sel   <= w_sel;
        end
    end

    // Output stage: load on transfer, drain when consumed, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_last  <= w_last;
            r_out_src   <= w_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_stream_arb_2x1.sv
// Directed bench for stream_arb_2x1: hand-computed expectations checked with immediate assertions.
module tb_stream_arb_2x1;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_src;
    logic             sel;

    int n_cmp;
    int n_err;

    stream_arb_2x1 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_last   (a_last),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_last   (b_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_src  (out_src),
        .sel      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the registered output beat.
    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l, input logic s);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".last"},  32'(out_last),  32'(l));
        chk({tag, ".src"},   32'(out_src),   32'(s));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // 1: reset with both sources requesting
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
        tick();
        chk("rst.a_ready", 32'(a_ready), 32'd0);
        chk("rst.b_ready", 32'(b_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sel", 32'(sel), 32'd0);
        tick();
        chk("rst2.out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel.sel", 32'(sel), 32'd0);
        chk("rel.a_ready", 32'(a_ready), 32'd1);
        chk("rel.b_ready", 32'(b_ready), 32'd0);

        // 2: single-beat packets alternate A,B,A,B
        tick(); chk_out("rr0", 1'b1, 8'h11, 1'b1, 1'b0);
        chk("rr0.sel", 32'(sel), 32'd1);
        tick(); chk_out("rr1", 1'b1, 8'h22, 1'b1, 1'b1);
        tick(); chk_out("rr2", 1'b1, 8'h11, 1'b1, 1'b0);
        tick(); chk_out("rr3", 1'b1, 8'h22, 1'b1, 1'b1);

        // 3: A 3-beat packet locks out B (prio is back at A)
        a_data = 8'hA0; a_last = 1'b0; b_data = 8'h33; b_last = 1'b1;
        #1; chk("pk0.b_ready", 32'(b_ready), 32'd0);
        tick(); chk_out("pk0", 1'b1, 8'hA0, 1'b0, 1'b0);
        a_data = 8'hA1;
        #1; chk("pk1.b_ready", 32'(b_ready), 32'd0);
        chk("pk1.sel", 32'(sel), 32'd0);
        tick(); chk_out("pk1", 1'b1, 8'hA1, 1'b0, 1'b0);
        a_data = 8'hA2; a_last = 1'b1;
        #1; chk("pk2.b_ready", 32'(b_ready), 32'd0);
        tick(); chk_out("pk2", 1'b1, 8'hA2, 1'b1, 1'b0);
        a_valid = 1'b0;
        #1; chk("pkb.sel", 32'(sel), 32'd1);
        tick(); chk_out("pkb", 1'b1, 8'h33, 1'b1, 1'b1);

        // 4: stall with out_ready=0 for 3 cycles mid-packet
        b_valid = 1'b0;
        a_valid = 1'b1; a_data = 8'hC0; a_last = 1'b0;
        tick(); chk_out("st0", 1'b1, 8'hC0, 1'b0, 1'b0);
        out_ready = 1'b0; a_data = 8'hC1; a_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st.a_ready", 32'(a_ready), 32'd0);
            chk("st.b_ready", 32'(b_ready), 32'd0);
            tick(); chk_out("st.hold", 1'b1, 8'hC0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1; chk("st.resume.a_ready", 32'(a_ready), 32'd1);
        tick(); chk_out("st1", 1'b1, 8'hC1, 1'b1, 1'b0);
        a_valid = 1'b0;
        tick(); chk_out("st.drain", 1'b0, 8'hC1, 1'b1, 1'b0);

        // 5: A valid gaps mid-packet do not release the lock to B
        a_valid = 1'b1; a_data = 8'hD0; a_last = 1'b0;
        tick(); chk_out("gp0", 1'b1, 8'hD0, 1'b0, 1'b0);
        a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h44; b_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("gp.sel", 32'(sel), 32'd0);
            chk("gp.b_ready", 32'(b_ready), 32'd0);
            tick(); chk("gp.out_valid", 32'(out_valid), 32'd0);
        end
        a_valid = 1'b1; a_data = 8'hD1; a_last = 1'b1;
        tick(); chk_out("gp1", 1'b1, 8'hD1, 1'b1, 1'b0);
        a_valid = 1'b0;
        tick(); chk_out("gpb", 1'b1, 8'h44, 1'b1, 1'b1);

        // 6: reset while B holds the lock
        b_data = 8'hE0; b_last = 1'b0;
        tick(); chk_out("rb0", 1'b1, 8'hE0, 1'b0, 1'b1);
        rst = 1'b1; b_data = 8'hE1;
        a_valid = 1'b1; a_data = 8'h55; a_last = 1'b1;
        #1;
        chk("rb.a_ready", 32'(a_ready), 32'd0);
        chk("rb.b_ready", 32'(b_ready), 32'd0);
        chk("rb.sel", 32'(sel), 32'd0);
        tick(); chk_out("rb.rst", 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rb.sel_after", 32'(sel), 32'd0);
        chk("rb.a_ready_after", 32'(a_ready), 32'd1);
        tick(); chk_out("rb1", 1'b1, 8'h55, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
